// File: rtl/pkg_en.sv
// pkg_en: token channel types, source FSM states and defaults for the RE link side
package pkg_en;
    localparam int WIDTH_DATA_EN = 32;
    localparam int DEPTH_BUF_DEF = 4;
    typedef struct packed {
        logic                     v;
        logic                     a;
        logic                     r;
        logic                     c;
        logic [WIDTH_DATA_EN-1:0] d;
    } FTk_t;
    typedef struct packed {
        logic n;
        logic t;
        logic v;
        logic c;
    } BTk_t;
    typedef enum logic [1:0] {IDLE, HDR, BODY, DONE} src_state_e;
endpackage

// File: rtl/re_stream_src_if.sv
// re_stream_src_if: host word stream plus forward/backward token channel of the source
interface re_stream_src_if #(
    parameter int WIDTH_DATA = pkg_en::WIDTH_DATA_EN
) ();
    logic [WIDTH_DATA-1:0] I_Data;
    logic                  I_Valid;
    logic                  O_Ready;
    pkg_en::FTk_t          O_FTk;
    pkg_en::BTk_t          I_BTk;
    modport master (input I_Data, I_Valid, I_BTk, output O_Ready, O_FTk);
    modport slave  (output I_Data, I_Valid, I_BTk, input O_Ready, O_FTk);
endinterface

// File: rtl/re_src_buf.sv
// re_src_buf: synchronous FIFO with push/pop/flush, full/empty and occupancy
module re_src_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] occ
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_q] = din;
        wr_d  = flush ? '0 : wr_q + AW'(push);
        rd_d  = flush ? '0 : rd_q + AW'(pop);
        cnt_d = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
    always_ff @(posedge clock) mem_q <= mem_d;
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    assign dout  = mem_q[rd_q];
    assign empty = cnt_q == '0;
    assign full  = cnt_q == (AW+1)'(DEPTH);
    assign occ   = cnt_q;
endmodule

// File: rtl/re_stream_src.sv
// re_stream_src: frames a buffered host word stream into an FTk block (optional header via RE_SRC_HDR_EN)
// with acquire/release marking, nack stall and term abort.
module re_stream_src import pkg_en::*; #(
    parameter int WIDTH_DATA   = WIDTH_DATA_EN,
    parameter int WIDTH_LENGTH = 10,
    parameter int DEPTH_BUF    = DEPTH_BUF_DEF
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    I_Start,
    input  logic [WIDTH_LENGTH-1:0] I_Length,
    input  logic [WIDTH_DATA-1:0]   I_Hdr,
    output logic                    O_Busy,
    output logic                    O_Done,
    output logic                    O_Abort,
    re_stream_src_if.master         bus
);
    localparam int AW = $clog2(DEPTH_BUF);
    src_state_e              state_q, state_d;
    logic [WIDTH_LENGTH-1:0] cnt_q, cnt_d, rem;
    FTk_t                    ftk_q, ftk_d;
    logic                    abort_q, abort_d, ready_q, ready_d, first_q, first_d;
    logic                    push, load, try_ld, flush, empty, full;
    logic [WIDTH_DATA-1:0]   head;
    logic [AW:0]             occ, occ_nxt;
    logic                    unused_ok;

    assign push = bus.I_Valid && ready_q;

    re_src_buf #(.WIDTH(WIDTH_DATA), .DEPTH(DEPTH_BUF)) u_buf (
        .clock(clock), .reset(reset), .push(push), .pop(load), .flush(flush),
        .din(bus.I_Data), .dout(head), .empty(empty), .full(full), .occ(occ)
    );

    // rem is the count left after this cycle's transfer; it decides whether the next token loads
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ftk_d   = ftk_q;
        first_d = first_q;
        abort_d = 1'b0;
        flush   = 1'b0;
        try_ld  = 1'b0;
        rem     = cnt_q;
        if ((state_q == HDR || state_q == BODY) && bus.I_BTk.t) begin
            state_d = DONE;
            cnt_d   = '0;
            ftk_d   = '0;
            first_d = 1'b0;
            abort_d = 1'b1;
            flush   = 1'b1;
        end else if (state_q == IDLE && I_Start) begin
            cnt_d = I_Length;
            rem   = I_Length;
`ifdef RE_SRC_HDR_EN
            state_d = HDR;
            ftk_d   = '{v: 1'b1, a: 1'b1, r: I_Length == '0, c: 1'b0, d: WIDTH_DATA_EN'(I_Hdr)};
`else
            state_d = (I_Length == '0) ? DONE : BODY;
            ftk_d   = '0;
            first_d = 1'b1;
            try_ld  = 1'b1;
`endif
        end else if (state_q == HDR && !bus.I_BTk.n) begin
            state_d = (cnt_q == '0) ? DONE : BODY;
            ftk_d   = '0;
            try_ld  = 1'b1;
        end else if (state_q == BODY && (!ftk_q.v || !bus.I_BTk.n)) begin
            rem     = cnt_q - WIDTH_LENGTH'(ftk_q.v);
            cnt_d   = rem;
            state_d = ftk_q.r ? DONE : BODY;
            ftk_d   = '0;
            try_ld  = 1'b1;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
        load = try_ld && rem != '0 && !empty;
        if (load) begin
            ftk_d   = '{v: 1'b1, a: first_d, r: rem == WIDTH_LENGTH'(1), c: 1'b0, d: WIDTH_DATA_EN'(head)};
            first_d = 1'b0;
        end
        occ_nxt = flush ? '0 : occ + (AW+1)'(push) - (AW+1)'(load);
        ready_d = occ_nxt < (AW+1)'(DEPTH_BUF);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ftk_q   <= '0;
            first_q <= 1'b0;
            abort_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ftk_q   <= ftk_d;
            first_q <= first_d;
            abort_q <= abort_d;
            ready_q <= ready_d;
        end
    end

    assign bus.O_FTk   = ftk_q;
    assign bus.O_Ready = ready_q;
    assign O_Busy      = state_q != IDLE;
    assign O_Done      = state_q == DONE;
    assign O_Abort     = abort_q;
`ifdef RE_SRC_HDR_EN
    assign unused_ok = ^{bus.I_BTk.v, bus.I_BTk.c, full};
`else
    assign unused_ok = ^{bus.I_BTk.v, bus.I_BTk.c, full, I_Hdr};
`endif
endmodule

// File: tb/tb_re_stream_src.sv
// tb_re_stream_src: directed scoreboard bench for re_stream_src (honours RE_SRC_HDR_EN)
module tb_re_stream_src;
    import pkg_en::*;
    localparam int H =
`ifdef RE_SRC_HDR_EN
        1;
`else
        0;
`endif
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [9:0]  len = '0;
    logic [31:0] hdr = '0;
    logic        busy, done, abort;
    int          checks = 0, errors = 0, xfers = 0, gaps = 0;
    logic [34:0] exp_q[$];
    bit          done_q[$];
    logic        hold_chk = 1'b0;
    FTk_t        hold_tok = '0;

    re_stream_src_if bus();
    re_stream_src dut (
        .clock(clk), .reset(rst), .I_Start(start), .I_Length(len), .I_Hdr(hdr),
        .O_Busy(busy), .O_Done(done), .O_Abort(abort), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic fail_msg(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [31:0] val(input logic [31:0] b, input int i);
        return b * 32'(i + 1);
    endfunction

    // scoreboard monitor: transfers, hold stability, idle zeros, done/abort pulses
    always @(negedge clk) begin
        if (hold_chk) chk("hold_stable", bus.O_FTk, hold_tok);
        hold_chk = bus.O_FTk.v && bus.I_BTk.n && !bus.I_BTk.t;
        hold_tok = bus.O_FTk;
        if (bus.O_FTk.v && !bus.I_BTk.n) begin
            xfers++;
            if (exp_q.size() == 0) fail_msg($sformatf("unexpected_token got d=%0h want none", bus.O_FTk.d));
            else chk("token", {bus.O_FTk.a, bus.O_FTk.r, bus.O_FTk.c, bus.O_FTk.d}, exp_q.pop_front());
        end else if (!bus.O_FTk.v) begin
            chk("idle_zero", bus.O_FTk, 0);
        end
        if (busy && !bus.O_FTk.v && !done) gaps++;
        if (done || abort) begin
            if (done_q.size() == 0) fail_msg($sformatf("unexpected_done got done=%0b abort=%0b want none", done, abort));
            else chk("done_abort", {done, abort}, {1'b1, done_q.pop_front()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d);
        int b = 0;
        bus.I_Data  = d;
        bus.I_Valid = 1'b1;
        while (!bus.O_Ready && b < 100) begin
            tick();
            b++;
        end
        if (b == 100) fail_msg("push_timeout got ready=0 want 1");
        tick();
        bus.I_Valid = 1'b0;
    endtask

    task automatic fill(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) push_word(val(base, i));
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        len   = 10'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int b = 0;
        while (busy && b < 300) begin
            tick();
            b++;
        end
        if (b == 300) fail_msg("idle_timeout got busy=1 want 0");
    endtask

    task automatic expect_block(input int n, input logic [31:0] base, input int nx, input bit dn, input bit ab);
        if (H == 1) exp_q.push_back({1'b1, n == 0, 1'b0, hdr});
        for (int i = 0; i < nx; i++) exp_q.push_back({H == 0 && i == 0, i == n - 1, 1'b0, val(base, i)});
        if (dn) done_q.push_back(ab);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, x0;
        bus.I_Data  = '0;
        bus.I_Valid = 1'b0;
        bus.I_BTk   = '0;
        tick();
        tick();
        chk("rst_ftk", bus.O_FTk, 0);
        chk("rst_ready", bus.O_Ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_abort", abort, 0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", bus.O_Ready, 1);

        // N=3 prefilled, no backpressure: back-to-back tokens then DONE
        hdr = 32'hAAAA_0001;
        fill(3, 32'h11);
        expect_block(3, 32'h11, 3, 1, 0);
        do_start(3);
        chk("a_busy", busy, 1);
        for (int i = 0; i <= H + 3; i++) begin
            chk($sformatf("a_v%0d", i), bus.O_FTk.v, i < H + 3);
            chk($sformatf("a_done%0d", i), done, i == H + 3);
            tick();
        end
        chk("a_busy_fall", busy, 0);

        // nack held 5 cycles on the second data token; a Start while busy is ignored
        hdr = 32'hAAAA_0002;
        fill(3, 32'h44);
        expect_block(3, 32'h44, 3, 1, 0);
        do_start(3);
        repeat (H + 1) tick();
        bus.I_BTk.n = 1'b1;
        chk("b_stall_d", bus.O_FTk.d, 32'h88);
        start = 1'b1;
        len   = 10'd1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        bus.I_BTk.n = 1'b0;
        b = 0;
        while (!done && b < 20) begin
            tick();
            b++;
        end
        chk("b_done_lat", b, 2);
        tick();
        tick();
        chk("b_no_restart", busy, 0);

        // trickle host: one word every 3 cycles
        hdr  = 32'hAAAA_0003;
        gaps = 0;
        expect_block(5, 32'h3, 5, 1, 0);
        fork
            do_start(5);
            for (int i = 0; i < 5; i++) begin
                push_word(val(32'h3, i));
                repeat (2) tick();
            end
        join
        wait_idle();
        chk("c_gaps", gaps > 0, 1);

        // term after 2 of 6 data tokens flushes the buffer
        hdr = 32'hAAAA_0004;
        fill(4, 32'h60);
        chk("d_full_ready", bus.O_Ready, 0);
        expect_block(6, 32'h60, 2, 1, 1);
        x0 = xfers;
        do_start(6);
        b = 0;
        while (xfers < x0 + H + 2 && b < 50) begin
            tick();
            b++;
        end
        if (b == 50) fail_msg("d_xfer_timeout");
        bus.I_BTk = '{n: 1'b1, t: 1'b1, v: 1'b0, c: 1'b0};
        tick();
        bus.I_BTk = '0;
        chk("d_done", done, 1);
        chk("d_abort", abort, 1);
        tick();
        chk("d_abort_pulse", abort, 0);
        chk("d_busy_fall", busy, 0);
        hdr = 32'hAAAA_0005;
        fill(2, 32'h70);
        expect_block(2, 32'h70, 2, 1, 0);
        do_start(2);
        wait_idle();

        // N=1 then N=0
        hdr = 32'hAAAA_0006;
        fill(1, 32'h5A);
        expect_block(1, 32'h5A, 1, 1, 0);
        do_start(1);
        wait_idle();
        hdr = 32'hAAAA_0007;
        expect_block(0, 32'h0, 0, 1, 0);
        do_start(0);
        chk("e_n0_done", done, H == 0);
        chk("e_n0_v", bus.O_FTk.v, H);
        wait_idle();

        // reset mid-block discards everything
        hdr = 32'hAAAA_0008;
        fill(3, 32'h90);
        expect_block(3, 32'h90, 1 - H, 0, 0);
        do_start(3);
        rst = 1'b1;
        tick();
        chk("f_ftk", bus.O_FTk, 0);
        chk("f_busy", busy, 0);
        chk("f_done", done, 0);
        chk("f_abort", abort, 0);
        chk("f_ready", bus.O_Ready, 0);
        rst = 1'b0;
        repeat (3) tick();
        hdr = 32'hAAAA_0009;
        fill(1, 32'hB0);
        expect_block(1, 32'hB0, 1, 1, 0);
        do_start(1);
        wait_idle();

        repeat (3) tick();
        chk("exp_q_empty", exp_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
